// File: rtl/finn_stream_classifier_pkg.sv
// Shared widths, FSM encoding and the fixed neuron weights of the stream classifier.
package finn_stream_classifier_pkg;

   localparam int IN_ELEMS = 5;
   localparam int IN_W     = 8;
   localparam int W_W      = 4;
   localparam int OUT_CH   = 4;
   localparam int ACC_W    = IN_W + W_W + $clog2(IN_ELEMS);
   localparam int CNT_W    = $clog2(OUT_CH);
   localparam int OUT_W    = 8;
   localparam int VEC_W    = IN_ELEMS * IN_W;
   localparam int WVEC_W   = IN_ELEMS * W_W;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPUTE = 2'd1;
   localparam logic [1:0] ST_OUTPUT  = 2'd2;

   // W[n][k]: weight of feature k in neuron n; all biases are zero.
   localparam logic signed [W_W-1:0] W [OUT_CH][IN_ELEMS] = '{
      '{4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0},
      '{4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0},
      '{4'sd0, 4'sd0, 4'sd1, 4'sd0, 4'sd0},
      '{4'sd0, 4'sd0, 4'sd0, 4'sd1, 4'sd1}
   };

endpackage

// File: rtl/finn_stream_classifier_if.sv
// AXI-Stream style valid/ready channel carrying a DATA_W-bit payload.
interface finn_stream_classifier_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/finn_stream_classifier_dot_unit.sv
// Combinational signed dot product of one feature vector with one neuron's weights.
module finn_dot_unit
   import finn_stream_classifier_pkg::*;
(
   input  logic [VEC_W-1:0]        x,
   input  logic [WVEC_W-1:0]       w,
   output logic signed [ACC_W-1:0] score
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] xe;
   logic signed [ACC_W-1:0] we;

   // NOTE: combinational logic uses blocking assignments and sets every output
   // before the loop, so the running sum is ordered and no latch is inferred.
   always_comb begin
      acc = '0;
      xe  = '0;
      we  = '0;
      for (int k = 0; k < IN_ELEMS; k++) begin
         xe  = ACC_W'(signed'(x[k*IN_W +: IN_W]));
         we  = ACC_W'(signed'(w[k*W_W +: W_W]));
         acc = acc + xe * we;
      end
   end

   assign score = acc;

endmodule

// File: rtl/finn_stream_classifier.sv
// Single-layer quantized classifier: accept a feature vector, score one neuron per
// cycle, keep a running argmax and emit the winning class index as one output beat.
module finn_stream_classifier
   import finn_stream_classifier_pkg::*;
(
   input  logic                          ap_clk,
   input  logic                          ap_rst,
   finn_stream_classifier_if.slave       s_axis_0,
   finn_stream_classifier_if.master      m_axis_0
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_CH - 1);

   logic [1:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic [VEC_W-1:0]        vec;
   logic signed [ACC_W-1:0] best_score;
   logic [CNT_W-1:0]        best_idx;
   logic [OUT_W-1:0]        out_data;
   logic                    out_valid;

   logic [WVEC_W-1:0]       w_sel;
   logic signed [ACC_W-1:0] score;
   logic                    take_new;
   logic signed [ACC_W-1:0] next_best;
   logic [CNT_W-1:0]        next_idx;

   always_comb begin
      w_sel = '0;
      for (int k = 0; k < IN_ELEMS; k++) begin
         w_sel[k*W_W +: W_W] = W[cnt][k];
      end
   end

   finn_dot_unit u_dot (
      .x     (vec),
      .w     (w_sel),
      .score (score)
   );

   // Strict compare: on a tie the earlier (lower) index keeps the lead.
   assign take_new  = (cnt == '0) || (score > best_score);
   assign next_best = take_new ? score : best_score;
   assign next_idx  = take_new ? cnt : best_idx;

   assign s_axis_0.tready = (state == ST_IDLE) && !ap_rst;
   assign m_axis_0.tdata  = out_data;
   assign m_axis_0.tvalid = out_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         vec        <= '0;
         best_score <= '0;
         best_idx   <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (s_axis_0.tvalid) begin
                  vec   <= s_axis_0.tdata;
                  cnt   <= '0;
                  state <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               best_score <= next_best;
               best_idx   <= next_idx;
               if (cnt == LAST_CNT) begin
                  out_data  <= OUT_W'(next_idx);
                  out_valid <= 1'b1;
                  state     <= ST_OUTPUT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_OUTPUT: begin
               if (m_axis_0.tready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_finn_stream_classifier.sv
// Directed and randomized bench for finn_stream_classifier against an argmax model.
module tb_finn_stream_classifier;

   localparam int WT [4][5] = '{
      '{1, 0, 0, 0, 0},
      '{0, 1, 0, 0, 0},
      '{0, 0, 1, 0, 0},
      '{0, 0, 0, 1, 1}
   };

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   finn_stream_classifier_if #(.DATA_W(40)) s_if ();
   finn_stream_classifier_if #(.DATA_W(8))  m_if ();

   finn_stream_classifier dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .s_axis_0 (s_if.slave),
      .m_axis_0 (m_if.master)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: score every class with integer arithmetic, keep the first maximum.
   function automatic int model(input logic [39:0] v);
      int best;
      int best_i;
      int s;
      logic signed [7:0] f;
      best   = 0;
      best_i = 0;
      for (int n = 0; n < 4; n++) begin
         s = 0;
         for (int k = 0; k < 5; k++) begin
            f = v[8*k +: 8];
            s += WT[n][k] * int'(f);
         end
         if (n == 0 || s > best) begin
            best   = s;
            best_i = n;
         end
      end
      return best_i;
   endfunction

   task automatic run_vector(input string tag, input logic [39:0] v, input int stall);
      int lat;
      int exp_idx;
      exp_idx = model(v);
      @(negedge ap_clk);
      check({tag, "_s_ready_idle"}, s_if.tready, 1);
      s_if.tdata  = v;
      s_if.tvalid = 1'b1;
      m_if.tready = (stall == 0);
      @(posedge ap_clk);
      #1;
      s_if.tvalid = 1'b0;
      s_if.tdata  = {$urandom, 8'($urandom)};
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge ap_clk);
         #1;
         if (m_if.tvalid === 1'b1) begin
            lat = i;
            break;
         end
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_data"}, m_if.tdata, exp_idx);
      check({tag, "_s_ready_busy"}, s_if.tready, 0);
      for (int i = 0; i < stall; i++) begin
         @(posedge ap_clk);
         #1;
         check({tag, "_stall_data"}, {m_if.tvalid, m_if.tdata}, {1'b1, 8'(exp_idx)});
      end
      m_if.tready = 1'b1;
      @(posedge ap_clk);
      #1;
      check({tag, "_valid_drop"}, m_if.tvalid, 0);
      check({tag, "_s_ready_back"}, s_if.tready, 1);
   endtask

   initial begin
      int beats;
      s_if.tdata  = '0;
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b0;

      // Reset held 100 ns, with input valid asserted to confirm it is refused.
      s_if.tvalid = 1'b1;
      s_if.tdata  = 40'h1122334455;
      for (int i = 0; i < 3; i++) begin
         #30;
         check("rst_s_ready", s_if.tready, 0);
         check("rst_m_valid", {m_if.tvalid, m_if.tdata}, 9'h000);
      end
      #10;
      @(negedge ap_clk);
      s_if.tvalid = 1'b0;
      ap_rst      = 1'b0;
      @(negedge ap_clk);
      check("post_rst_s_ready", s_if.tready, 1);
      check("post_rst_m_valid", m_if.tvalid, 0);

      // Directed vectors from the documented cases.
      run_vector("vec_abcde", 40'h00000ABCDE, 0);
      check("vec_abcde_const", m_if.tdata, 8'h02);
      run_vector("vec_zero", 40'h0000000000, 0);
      check("vec_zero_const", m_if.tdata, 8'h00);
      run_vector("vec_n3", 40'h0203000000, 0);
      check("vec_n3_const", m_if.tdata, 8'h03);

      // Long backpressure with junk driven on the input side.
      @(negedge ap_clk);
      s_if.tdata  = 40'h00FF7F0180;
      s_if.tvalid = 1'b1;
      m_if.tready = 1'b0;
      @(posedge ap_clk);
      #1;
      beats = 0;
      for (int i = 0; i < 20 && m_if.tvalid !== 1'b1; i++) begin
         @(posedge ap_clk);
         #1;
      end
      check("bp_valid_rise", m_if.tvalid, 1);
      for (int i = 0; i < 20; i++) begin
         s_if.tdata = {$urandom, 8'($urandom)};
         @(posedge ap_clk);
         #1;
         check("bp_hold", {m_if.tvalid, m_if.tdata, s_if.tready},
               {1'b1, 8'(model(40'h00FF7F0180)), 1'b0});
      end
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge ap_clk);
         if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) beats++;
         #1;
         if (i == 0) check("bp_s_ready_after", s_if.tready, 1);
      end
      check("bp_one_beat", beats, 1);

      // Reset during COMPUTE discards the vector.
      @(negedge ap_clk);
      s_if.tdata  = 40'h0000000042;
      s_if.tvalid = 1'b1;
      @(posedge ap_clk);
      #1;
      s_if.tvalid = 1'b0;
      @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst = 1'b1;
      #1;
      check("mid_rst_m_valid", m_if.tvalid, 0);
      check("mid_rst_s_ready", s_if.tready, 0);
      @(negedge ap_clk);
      @(negedge ap_clk);
      ap_rst = 1'b0;
      beats  = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge ap_clk);
         #1;
         if (m_if.tvalid !== 1'b0) beats++;
      end
      check("mid_rst_no_beat", beats, 0);
      run_vector("vec_7f", 40'h000000007F, 0);
      check("vec_7f_const", m_if.tdata, 8'h00);

      // Randomized vectors with random backpressure.
      for (int r = 0; r < 25; r++) begin
         run_vector($sformatf("rand%0d", r), {$urandom, 8'($urandom)}, int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
